// File: rtl/fetch_pkg.sv
// Shared widths, entry layout and pointer sizing for the instruction fetch queue.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 8;
  localparam int FETCH_DATA_W = 32;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] addr;
    logic [FETCH_DATA_W-1:0] data;
    logic                    filled;
  } fetch_entry_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Entry storage for the fetch queue: allocate, in-order fill and head pointers
// plus the allocated and not-yet-filled entry counts.
module fetch_buf import fetch_pkg::*; #(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W,
  parameter int DEPTH  = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              alloc_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic              fill_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              deq_i,
  output logic              head_filled_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  used_o,
  output logic [CNT_W-1:0]  unfilled_o
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;
  logic [PTR_W-1:0]  alloc_q, alloc_d;
  logic [PTR_W-1:0]  fill_q, fill_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [CNT_W-1:0]  used_q, used_d;
  logic [CNT_W-1:0]  unfilled_q, unfilled_d;

  // A flush snaps fill and head onto alloc, leaving the queue empty in place.
  always_comb begin
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    used_d     = used_q;
    unfilled_d = unfilled_q;
    if (flush_i) begin
      fill_d     = alloc_q;
      head_d     = alloc_q;
      used_d     = '0;
      unfilled_d = '0;
    end else begin
      if (alloc_i) alloc_d = alloc_q + PTR_W'(1);
      if (fill_i)  fill_d  = fill_q + PTR_W'(1);
      if (deq_i)   head_d  = head_q + PTR_W'(1);
      used_d     = used_q + CNT_W'(alloc_i) - CNT_W'(deq_i);
      unfilled_d = unfilled_q + CNT_W'(alloc_i) - CNT_W'(fill_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      used_q     <= '0;
      unfilled_q <= '0;
      filled_q   <= '0;
    end else begin
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      used_q     <= used_d;
      unfilled_q <= unfilled_d;
      if (flush_i) begin
        filled_q <= '0;
      end else begin
        if (alloc_i) filled_q[alloc_q] <= 1'b0;
        if (fill_i)  filled_q[fill_q]  <= 1'b1;
        if (deq_i)   filled_q[head_q]  <= 1'b0;
      end
    end
  end

  // Payload needs no reset: filled_q qualifies every read of it.
  always_ff @(posedge clk) begin
    if (alloc_i && !flush_i) addr_q[alloc_q] <= alloc_addr_i;
    if (fill_i && !flush_i)  data_q[fill_q]  <= fill_data_i;
  end

  assign head_filled_o = filled_q[head_q];
  assign head_addr_o   = addr_q[head_q];
  assign head_data_o   = data_q[head_q];
  assign used_o        = used_q;
  assign unfilled_o    = unfilled_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order memory reads for accepted PCs and
// buffers returned words for decode, discarding responses from flushed paths.
module fetch_queue import fetch_pkg::*; #(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_valid_i,
  input  logic [ADDR_W-1:0] pc_addr_i,
  output logic              pc_ready_o,
  input  logic              redirect_i,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_req_ready_i,
  input  logic              mem_rsp_valid_i,
  input  logic [DATA_W-1:0] mem_rsp_data_i,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_data_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i,
  output logic              busy_o
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] used, unfilled;
  logic             head_filled;
  logic             can_acc, accept, fill, deq;

  // Outstanding requests, live or stale, are capped at DEPTH so drop never overflows.
  always_comb begin
    can_acc         = !redirect_i && (used < CNT_W'(DEPTH))
                      && ((SUM_W'(drop_q) + SUM_W'(unfilled)) < SUM_W'(DEPTH));
    pc_ready_o      = mem_req_ready_i && can_acc;
    mem_req_valid_o = pc_valid_i && can_acc;
    mem_req_addr_o  = pc_addr_i;
    accept          = pc_valid_i && pc_ready_o;
    fill            = mem_rsp_valid_i && (drop_q == '0) && (unfilled != '0) && !redirect_i;
    instr_valid_o   = head_filled && (used != '0) && !redirect_i;
    deq             = instr_valid_o && instr_ready_i;
    busy_o          = (used != '0) || (drop_q != '0);
  end

  // On redirect every unfilled entry becomes a stale response, less one returning now.
  always_comb begin
    drop_d = drop_q;
    if (redirect_i) begin
      if (mem_rsp_valid_i && ((drop_q != '0) || (unfilled != '0)))
        drop_d = drop_q + unfilled - CNT_W'(1);
      else
        drop_d = drop_q + unfilled;
    end else if (mem_rsp_valid_i && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  fetch_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_i),
    .alloc_i      (accept),
    .alloc_addr_i (pc_addr_i),
    .fill_i       (fill),
    .fill_data_i  (mem_rsp_data_i),
    .deq_i        (deq),
    .head_filled_o(head_filled),
    .head_addr_o  (instr_pc_o),
    .head_data_o  (instr_data_o),
    .used_o       (used),
    .unfilled_o   (unfilled)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order memory model with fixed latency
// and a scoreboard of expected {pc, data} pairs popped as decode consumes them.
module tb_fetch_queue;

  typedef struct { logic [7:0] addr; int due; } pend_t;
  typedef struct { logic [7:0] pc; logic [31:0] data; } exp_t;
  typedef struct {
    logic [7:0]  gpc;
    logic [31:0] gdata;
    logic [7:0]  epc;
    logic [31:0] edata;
    int          cyc;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        pc_valid;
  logic [7:0]  pc_addr;
  logic        pc_ready;
  logic        redirect;
  logic        mem_req_valid;
  logic [7:0]  mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [7:0]  instr_pc;
  logic        instr_ready;
  logic        busy;

  int    vectors;
  int    miscompares;
  int    cyc;
  int    mem_lat;
  pend_t pend_q[$];
  exp_t  exp_q[$];
  res_t  res_q[$];

  fetch_queue #(.ADDR_W(8), .DATA_W(32), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_valid_i     (pc_valid),
    .pc_addr_i      (pc_addr),
    .pc_ready_o     (pc_ready),
    .redirect_i     (redirect),
    .mem_req_valid_o(mem_req_valid),
    .mem_req_addr_o (mem_req_addr),
    .mem_req_ready_i(mem_req_ready),
    .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_data_i (mem_rsp_data),
    .instr_valid_o  (instr_valid),
    .instr_data_o   (instr_data),
    .instr_pc_o     (instr_pc),
    .instr_ready_i  (instr_ready),
    .busy_o         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memword(input logic [7:0] a);
    return 32'h0000_00A0 + 32'(a[7:2]);
  endfunction

  // Samples handshakes mid-cycle, then advances one clock and drives the memory response.
  task automatic tick();
    bit   in_reset;
    res_t r;
    exp_t e;
    @(negedge clk);
    in_reset = !rst_n;
    if (!in_reset) begin
      if (mem_req_valid && mem_req_ready)
        pend_q.push_back('{addr: mem_req_addr, due: cyc + mem_lat});
      if (instr_valid && instr_ready) begin
        r.gpc   = instr_pc;
        r.gdata = instr_data;
        r.cyc   = cyc;
        if (exp_q.size() > 0) begin
          e       = exp_q.pop_front();
          r.epc   = e.pc;
          r.edata = e.data;
        end else begin
          r.epc   = 'x;
          r.edata = 'x;
        end
        res_q.push_back(r);
      end
      if (redirect) exp_q.delete();
      else if (pc_valid && pc_ready)
        exp_q.push_back('{pc: pc_addr, data: memword(pc_addr)});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (in_reset) begin
      pend_q.delete();
      exp_q.delete();
      res_q.delete();
    end
    if (!in_reset && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = memword(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    pc_valid      = 1'b0;
    pc_addr       = 8'h00;
    redirect      = 1'b0;
    instr_ready   = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    pc_valid = 1'b1;
    pc_addr  = 8'h5C;
    #1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (pc_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_pc_ready: got %b expected 1", pc_ready); end
    vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_req_valid: got %b expected 1", mem_req_valid); end
    vectors++; if (mem_req_addr !== 8'h5C) begin miscompares++; $display("[TB] FAIL reset_req_addr: got %h expected 5c", mem_req_addr); end
    mem_req_ready = 1'b0;
    #1;
    vectors++; if (pc_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL comb_pc_ready: got %b expected 0", pc_ready); end
    vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL comb_req_valid: got %b expected 1", mem_req_valid); end
    pc_valid = 1'b0;
    #1;
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_req_valid: got %b expected 0", mem_req_valid); end
    mem_req_ready = 1'b1;
  endtask

  task automatic test_streaming();
    int   start;
    int   n;
    res_t r;
    do_reset();
    mem_lat     = 1;
    instr_ready = 1'b1;
    start       = cyc;
    for (int i = 0; i < 4; i++) begin
      pc_valid = 1'b1;
      pc_addr  = 8'(i * 4);
      #1;
      vectors++; if (pc_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_ready%0d: got %b expected 1", i, pc_ready); end
      tick();
    end
    pc_valid = 1'b0;
    repeat (5) tick();
    vectors++; if (res_q.size() != 4) begin miscompares++; $display("[TB] FAIL stream_count: got %0d expected 4", res_q.size()); end
    n = 0;
    while (res_q.size() > 0) begin
      r = res_q.pop_front();
      vectors++; if (r.gpc !== r.epc || r.gdata !== r.edata) begin miscompares++; $display("[TB] FAIL stream_pair%0d: got pc %h data %h expected pc %h data %h", n, r.gpc, r.gdata, r.epc, r.edata); end
      vectors++; if (r.cyc != start + 2 + n) begin miscompares++; $display("[TB] FAIL stream_cycle%0d: got %0d expected %0d", n, r.cyc - start, 2 + n); end
      n++;
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full();
    res_t r;
    int   n;
    do_reset();
    mem_lat     = 1;
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc_valid = 1'b1;
      pc_addr  = 8'h10 + 8'(i * 4);
      #1;
      vectors++; if (pc_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL full_fill_ready%0d: got %b expected 1", i, pc_ready); end
      tick();
    end
    pc_addr = 8'h20;
    #1;
    vectors++; if (pc_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready_a: got %b expected 0", pc_ready); end
    tick();
    #1;
    vectors++; if (pc_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready_b: got %b expected 0", pc_ready); end
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 8'h10) begin miscompares++; $display("[TB] FAIL full_head: got valid %b pc %h expected valid 1 pc 10", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    #1;
    vectors++; if (pc_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_deq_cycle_ready: got %b expected 0", pc_ready); end
    tick();
    instr_ready = 1'b0;
    #1;
    vectors++; if (pc_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL full_resume_ready: got %b expected 1", pc_ready); end
    tick();
    pc_valid    = 1'b0;
    instr_ready = 1'b1;
    repeat (8) tick();
    vectors++; if (res_q.size() != 5) begin miscompares++; $display("[TB] FAIL full_count: got %0d expected 5", res_q.size()); end
    n = 0;
    while (res_q.size() > 0) begin
      r = res_q.pop_front();
      vectors++; if (r.gpc !== r.epc || r.gdata !== r.edata) begin miscompares++; $display("[TB] FAIL full_pair%0d: got pc %h data %h expected pc %h data %h", n, r.gpc, r.gdata, r.epc, r.edata); end
      n++;
    end
  endtask

  task automatic test_redirect_inflight();
    int   t0;
    res_t r;
    do_reset();
    mem_lat     = 4;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1;
      pc_addr  = 8'(i * 4);
      tick();
    end
    pc_valid = 1'b0;
    redirect = 1'b1;
    #1;
    vectors++; if (pc_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_pc_ready: got %b expected 0", pc_ready); end
    tick();
    redirect = 1'b0;
    pc_valid = 1'b1;
    pc_addr  = 8'h40;
    #1;
    vectors++; if (pc_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL redir_next_ready: got %b expected 1", pc_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL redir_busy_drop: got %b expected 1", busy); end
    t0 = cyc;
    tick();
    pc_valid = 1'b0;
    repeat (12) tick();
    vectors++; if (res_q.size() != 1) begin miscompares++; $display("[TB] FAIL redir_count: got %0d expected 1", res_q.size()); end
    if (res_q.size() > 0) begin
      r = res_q.pop_front();
      vectors++; if (r.gpc !== 8'h40 || r.gdata !== r.edata || r.epc !== 8'h40) begin miscompares++; $display("[TB] FAIL redir_pair: got pc %h data %h expected pc 40 data %h", r.gpc, r.gdata, r.edata); end
      vectors++; if (r.cyc != t0 + mem_lat + 1) begin miscompares++; $display("[TB] FAIL redir_cycle: got %0d expected %0d", r.cyc - t0, mem_lat + 1); end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_redirect_rsp();
    int   t0;
    res_t r;
    do_reset();
    mem_lat     = 2;
    instr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pc_valid = 1'b1;
      pc_addr  = 8'(i * 4);
      tick();
    end
    pc_valid = 1'b0;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    pc_valid = 1'b1;
    pc_addr  = 8'h40;
    #1;
    vectors++; if (pc_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rsp_redir_ready: got %b expected 1", pc_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rsp_redir_busy: got %b expected 1", busy); end
    t0 = cyc;
    tick();
    pc_valid = 1'b0;
    repeat (8) tick();
    vectors++; if (res_q.size() != 1) begin miscompares++; $display("[TB] FAIL rsp_redir_count: got %0d expected 1", res_q.size()); end
    if (res_q.size() > 0) begin
      r = res_q.pop_front();
      vectors++; if (r.gpc !== 8'h40 || r.gdata !== r.edata || r.epc !== 8'h40) begin miscompares++; $display("[TB] FAIL rsp_redir_pair: got pc %h data %h expected pc 40 data %h", r.gpc, r.gdata, r.edata); end
      vectors++; if (r.cyc != t0 + 3) begin miscompares++; $display("[TB] FAIL rsp_redir_cycle: got %0d expected 3", r.cyc - t0); end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rsp_redir_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    res_t r;
    int   n;
    do_reset();
    mem_lat     = 1;
    instr_ready = 1'b0;
    pc_valid    = 1'b1;
    pc_addr     = 8'h00;
    tick();
    pc_addr = 8'h04;
    tick();
    pc_addr     = 8'h08;
    instr_ready = 1'b1;
    #1;
    vectors++; if (pc_ready !== 1'b1 || instr_valid !== 1'b1 || instr_pc !== 8'h00) begin miscompares++; $display("[TB] FAIL b2b_all3: got ready %b valid %b pc %h expected 1 1 00", pc_ready, instr_valid, instr_pc); end
    tick();
    instr_ready = 1'b0;
    pc_addr     = 8'h0C;
    #1;
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 8'h04) begin miscompares++; $display("[TB] FAIL b2b_head: got valid %b pc %h expected 1 04", instr_valid, instr_pc); end
    vectors++; if (pc_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready_used2: got %b expected 1", pc_ready); end
    tick();
    pc_addr = 8'h10;
    #1;
    vectors++; if (pc_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready_used3: got %b expected 1", pc_ready); end
    tick();
    pc_addr = 8'h14;
    #1;
    vectors++; if (pc_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_ready_used4: got %b expected 0", pc_ready); end
    tick();
    pc_valid    = 1'b0;
    instr_ready = 1'b1;
    repeat (8) tick();
    vectors++; if (res_q.size() != 5) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d expected 5", res_q.size()); end
    n = 0;
    while (res_q.size() > 0) begin
      r = res_q.pop_front();
      vectors++; if (r.gpc !== r.epc || r.gdata !== r.edata || r.gpc !== 8'(n * 4)) begin miscompares++; $display("[TB] FAIL b2b_pair%0d: got pc %h data %h expected pc %h data %h", n, r.gpc, r.gdata, 8'(n * 4), r.edata); end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    do_reset();
    mem_lat     = 2;
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1;
      pc_addr  = 8'(i * 4);
      tick();
    end
    pc_valid = 1'b0;
    #1;
    vectors++; if (instr_valid !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_pre: got valid %b busy %b expected 1 1", instr_valid, busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_instr_valid: got %b expected 0", instr_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    pc_valid    = 1'b1;
    pc_addr     = 8'h20;
    instr_ready = 1'b1;
    tick();
    pc_valid = 1'b0;
    repeat (6) tick();
    vectors++; if (res_q.size() != 1) begin miscompares++; $display("[TB] FAIL mid_count: got %0d expected 1", res_q.size()); end
    if (res_q.size() > 0) begin
      r = res_q.pop_front();
      vectors++; if (r.gpc !== 8'h20 || r.gdata !== 32'h0000_00A8) begin miscompares++; $display("[TB] FAIL mid_pair: got pc %h data %h expected pc 20 data 000000a8", r.gpc, r.gdata); end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy_end: got %b expected 0", busy); end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    cyc           = 0;
    mem_lat       = 1;
    rst_n         = 1'b0;
    pc_valid      = 1'b0;
    pc_addr       = 8'h00;
    redirect      = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    instr_ready   = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    test_full();
    test_redirect_inflight();
    test_redirect_rsp();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
